// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and anode helper for the 4-digit
// seven-segment scanner.
package seg_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Per-slot cycle counter. Counts 0..SCAN_DIV-1 while run is high and
// flags the last blanked cycle and the last cycle of the slot.
module scan_timer #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic blank_done,
    output logic slot_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Slot counter: held at 0 when stopped, wraps at the end of each slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!run || cnt == SLOT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Strobes are gated by run so a stopped timer never advances the FSM.
    always_comb begin
        blank_done = run && (cnt == BLANK_LAST);
        slot_done  = run && (cnt == SLOT_LAST);
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed 4-digit seven-segment driver. Each digit gets a slot of
// SCAN_DIV cycles: BLANK_CYCLES of ghosting guard, then the digit shown.
// New patterns are staged in shadow registers and moved to the display
// registers only at a frame boundary so a frame never mixes old and new.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       update_ack,
    output logic       frame_start
);

    scan_state_t state, state_n;
    logic [1:0]  idx, idx_n;
    logic        boundary;
    logic        run, blank_done, slot_done;
    logic        pending;

    logic [NUM_DIGITS-1:0][7:0] seg_in;
    logic [NUM_DIGITS-1:0][7:0] shadow;
    logic [NUM_DIGITS-1:0][7:0] display;

    assign seg_in = {seg3, seg2, seg1, seg0};

    // Timer only runs once a slot is in progress; IDLE keeps it at 0.
    assign run = en && (state != ST_IDLE);

    scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    // Next-state decode; boundary marks the edge that enters BLANK for digit 0.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        boundary = 1'b0;
        if (!en) begin
            state_n = ST_IDLE;
            idx_n   = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n  = ST_BLANK;
                    idx_n    = 2'd0;
                    boundary = 1'b1;
                end
                ST_BLANK: begin
                    if (blank_done)
                        state_n = ST_SHOW;
                end
                ST_SHOW: begin
                    if (slot_done) begin
                        state_n  = ST_BLANK;
                        idx_n    = idx + 2'd1;
                        boundary = (idx == 2'd3);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    idx_n   = 2'd0;
                end
            endcase
        end
    end

    // State, pattern staging and registered outputs. Outputs are loaded
    // from the next-state decode so they settle on the edge the state moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            pending     <= 1'b0;
            shadow      <= {NUM_DIGITS{SEG_BLANK}};
            display     <= {NUM_DIGITS{SEG_BLANK}};
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            update_ack  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            frame_start <= boundary;
            update_ack  <= 1'b0;

            // A load landing on the boundary bypasses the shadow stage.
            if (load && boundary) begin
                shadow     <= seg_in;
                display    <= seg_in;
                pending    <= 1'b0;
                update_ack <= 1'b1;
            end else if (boundary && pending) begin
                display    <= shadow;
                pending    <= 1'b0;
                update_ack <= 1'b1;
            end else if (load) begin
                shadow  <= seg_in;
                pending <= 1'b1;
            end

            if (state_n == ST_SHOW) begin
                an  <= an_select(idx_n);
                seg <= display[idx_n];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner with SCAN_DIV=8, BLANK_CYCLES=2.
// The reference model tracks the position inside a 32-cycle frame and
// derives anode/segment values from slot arithmetic.
module tb_seg_display_scanner;

    localparam int S     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * S;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [7:0] s0, s1, s2, s3;
    logic [3:0] an;
    logic [7:0] seg;
    logic       update_ack, frame_start;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_idle;
    int         m_pos;
    logic [7:0] m_disp [4];
    logic [7:0] m_shad [4];
    bit         m_pend, m_ack, m_fs;

    seg_display_scanner #(.SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .seg0        (s0),
        .seg1        (s1),
        .seg2        (s2),
        .seg3        (s3),
        .an          (an),
        .seg         (seg),
        .update_ack  (update_ack),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idle = 1;
        m_pos  = 0;
        for (int i = 0; i < 4; i++) begin
            m_disp[i] = 8'hFF;
            m_shad[i] = 8'hFF;
        end
        m_pend = 0;
        m_ack  = 0;
        m_fs   = 0;
    endtask

    // One rising edge with the inputs currently applied.
    task automatic model_edge();
        logic [7:0] in_v [4];
        bit bnd;
        in_v[0] = s0; in_v[1] = s1; in_v[2] = s2; in_v[3] = s3;
        if (rst) begin
            model_reset();
            return;
        end
        bnd = en && (m_idle || m_pos == FRAME - 1);
        if (!en) begin
            m_idle = 1;
            m_pos  = 0;
        end else if (m_idle) begin
            m_idle = 0;
            m_pos  = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        m_fs  = bnd;
        m_ack = 0;
        if (load && bnd) begin
            for (int i = 0; i < 4; i++) begin
                m_disp[i] = in_v[i];
                m_shad[i] = in_v[i];
            end
            m_pend = 0;
            m_ack  = 1;
        end else if (bnd && m_pend) begin
            for (int i = 0; i < 4; i++) m_disp[i] = m_shad[i];
            m_pend = 0;
            m_ack  = 1;
        end else if (load) begin
            for (int i = 0; i < 4; i++) m_shad[i] = in_v[i];
            m_pend = 1;
        end
    endtask

    function automatic bit m_shown();
        return !m_idle && (m_pos % S) >= B;
    endfunction

    function automatic int m_digit();
        return m_pos / S;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] one;
        one = 4'b0001;
        if (!m_shown()) return 4'b1111;
        return ~(one << m_digit());
    endfunction

    function automatic logic [7:0] exp_seg();
        if (!m_shown()) return 8'hFF;
        return m_disp[m_digit()];
    endfunction

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("an",          {4'h0, an},          {4'h0, exp_an()});
        chk("seg",         seg,                 exp_seg());
        chk("update_ack",  {7'h0, update_ack},  {7'h0, m_ack});
        chk("frame_start", {7'h0, frame_start}, {7'h0, m_fs});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_pats();
        s0 = 8'($urandom); s1 = 8'($urandom);
        s2 = 8'($urandom); s3 = 8'($urandom);
    endtask

    task automatic pulse_load();
        load = 1;
        step();
        load = 0;
    endtask

    // mode 0: digit-2 shown, 1: last cycle of frame, 2: digit-0 shown, 3: digit-1 shown
    function automatic bit cond(input int mode);
        case (mode)
            0: return m_shown() && m_digit() == 2;
            1: return !m_idle && m_pos == FRAME - 1;
            2: return m_shown() && m_digit() == 0;
            3: return m_shown() && m_digit() == 1;
            default: return 0;
        endcase
    endfunction

    task automatic wait_for(input int mode);
        int n;
        n = 0;
        while (!cond(mode) && n < 4 * FRAME) begin
            step();
            n++;
        end
        if (!cond(mode)) begin
            checks++;
            errors++;
            $error("FAIL wait_for mode %0d: observed timeout expected condition", mode);
        end
    endtask

    initial begin
        rst = 0; en = 0; load = 0;
        s0 = 8'hFF; s1 = 8'hFF; s2 = 8'hFF; s3 = 8'hFF;
        #2 rst = 1;
        model_reset();
        #1 check_all();
        run(2);
        rst = 0;
        run(2);

        // scan order with the reference digit patterns, loaded while idle
        s0 = 8'hC0; s1 = 8'hF9; s2 = 8'hA4; s3 = 8'hB0;
        pulse_load();
        run(2);
        en = 1;
        run(3 * FRAME);

        // deferred update from the digit-2 slot
        wait_for(0);
        rand_pats();
        pulse_load();
        run(FRAME + 4);

        // load coincident with the frame boundary
        wait_for(1);
        rand_pats();
        pulse_load();
        run(FRAME + 4);

        // back-to-back loads while pending: last one wins
        wait_for(2);
        rand_pats();
        pulse_load();
        rand_pats();
        pulse_load();
        run(FRAME + 4);

        // drop enable during digit 1 with an update pending
        wait_for(3);
        rand_pats();
        pulse_load();
        en = 0;
        run(4);
        en = 1;
        run(FRAME + 4);

        // asynchronous reset between edges
        wait_for(0);
        #3 rst = 1;
        model_reset();
        #1 check_all();
        step();
        rst = 0;
        run(FRAME + 4);

        // randomized enable/load traffic
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 19) != 0);
            load = ($urandom_range(0, 9) == 0);
            rand_pats();
            step();
        end
        load = 0;
        en = 1;
        run(FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
